lsu_unit: RTL and testbench



---
 rtl/lsu_unit.sv | 167 ++++++++++++++++
 tb/tb_lsu_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_unit.sv
// Load/store unit: turns core byte-addressed requests into a word bus
// with byte enables, formats load data and stalls the core until done.
module lsu_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        access_fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic [31:0] r_cnt;
    logic [31:0] r_rdata;
    logic        r_fault;

    logic        w_req;
    logic        w_stall;
    logic        w_issue;
    logic        w_tout;
    logic        w_we;
    logic [2:0]  w_size;
    logic [31:0] w_addr;
    logic [31:0] w_wd;

    function automatic logic [3:0] be_of(input logic we, input logic [2:0] sz,
                                         input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        if (we) begin
            unique case (sz[1:0])
                2'd0:    be = 4'b0001 << off;
                2'd1:    be = off[1] ? 4'b1100 : 4'b0011;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] wd_of(input logic [2:0] sz,
                                          input logic [31:0] wd);
        logic [31:0] d;
        unique case (sz[1:0])
            2'd0:    d = {4{wd[7:0]}};
            2'd1:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] fmt(input logic [2:0] sz,
                                        input logic [1:0] off,
                                        input logic [31:0] d);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        sh = d >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? d[31:16] : d[15:0];
        unique case (sz[1:0])
            2'd0:    r = sz[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'd1:    r = sz[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    assign w_issue = (r_state == S_IDLE) && core_req_i;
    assign w_tout  = (TIMEOUT != 0) && (r_cnt == TIMEOUT - 1);

    // During the issue cycle the bus sees the core inputs directly.
    assign w_we   = w_issue ? core_we_i   : r_we;
    assign w_size = w_issue ? core_size_i : r_size;
    assign w_addr = w_issue ? core_addr_i : r_addr;
    assign w_wd   = w_issue ? core_wd_i   : r_wd;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_stall = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_req   = core_req_i;
                w_stall = core_req_i;
                if (core_req_i) w_next = S_WAIT;
            end
            S_WAIT: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (mem_ready_i || w_tout) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_we    <= 1'b0;
            r_size  <= 3'd0;
            r_addr  <= 32'd0;
            r_wd    <= 32'd0;
            r_cnt   <= 32'd0;
            r_rdata <= 32'd0;
            r_fault <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            if (w_issue) begin
                r_we   <= core_we_i;
                r_size <= core_size_i;
                r_addr <= core_addr_i;
                r_wd   <= core_wd_i;
                r_cnt  <= 32'd0;
            end
            // Load data is formatted on capture so core_rd_o holds afterwards.
            if (r_state == S_WAIT) begin
                if (mem_ready_i) begin
                    r_rdata <= r_we ? 32'd0 : fmt(r_size, r_addr[1:0], mem_rd_i);
                end else if (w_tout) begin
                    r_rdata <= 32'd0;
                    r_fault <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
        end
    end

    assign core_rd_o      = rst_i ? r_rdata : 32'd0;
    assign core_stall_o   = rst_i & w_stall;
    assign access_fault_o = rst_i & r_fault;
    assign mem_req_o      = rst_i & w_req;
    assign mem_we_o       = rst_i & w_req & w_we;
    assign mem_be_o       = (rst_i && w_req) ? be_of(w_we, w_size, w_addr[1:0]) : 4'd0;
    assign mem_addr_o     = (rst_i && w_req) ? {w_addr[31:2], 2'b00} : 32'd0;
    assign mem_wd_o       = (rst_i && w_req) ? wd_of(w_size, w_wd) : 32'd0;

endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboard bench for lsu_unit: stimulus pushes expected transactions,
// a negedge monitor checks bus outputs and completion results.
module tb_lsu_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        access_fault_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    lsu_unit #(.TIMEOUT(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .core_req_i     (core_req_i),
        .core_we_i      (core_we_i),
        .core_size_i    (core_size_i),
        .core_addr_i    (core_addr_i),
        .core_wd_i      (core_wd_i),
        .core_rd_o      (core_rd_o),
        .core_stall_o   (core_stall_o),
        .access_fault_o (access_fault_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wd_o       (mem_wd_o),
        .mem_rd_i       (mem_rd_i),
        .mem_ready_i    (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        fault;
        int          stalls;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_req = 1'b0;
    int   stall_cnt = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", n, act, want);
        end
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            prev_req  = 1'b0;
            stall_cnt = 0;
        end else begin
            if (mem_req_o) begin
                if (q.size() == 0) begin
                    chk("req_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("mem_addr", mem_addr_o, q[0].addr);
                    chk("mem_be", {28'd0, mem_be_o}, {28'd0, q[0].be});
                    chk("mem_wd", mem_wd_o, q[0].wd);
                    chk("mem_we", {31'd0, mem_we_o}, {31'd0, q[0].we});
                end
            end
            if (prev_req && !mem_req_o) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("core_rd", core_rd_o, e.rd);
                    chk("fault_done", {31'd0, access_fault_o}, {31'd0, e.fault});
                    chk("stall_cycles", stall_cnt, e.stalls);
                end
                stall_cnt = 0;
            end else begin
                chk("fault_idle", {31'd0, access_fault_o}, 32'd0);
                stall_cnt = core_stall_o ? stall_cnt + 1 : 0;
            end
            prev_req = mem_req_o;
        end
    end

    task automatic push(input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input logic fault, input int stalls);
        exp_t e;
        e.we = we; e.be = be; e.addr = {a[31:2], 2'b00}; e.wd = wd;
        e.rd = rd; e.fault = fault; e.stalls = stalls;
        q.push_back(e);
    endtask

    // wn = WAIT cycle in which ready is given; 0 = never (timeout).
    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdata, input int wn,
                          input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic [31:0] erd);
        push(we, a, ebe, ewd, erd, wn == 0, (wn == 0) ? 5 : wn + 1);
        @(posedge clk_i) #1;
        core_req_i = 1'b1; core_we_i = we; core_size_i = sz;
        core_addr_i = a; core_wd_i = wd;
        @(posedge clk_i) #1;
        core_req_i = 1'b0; core_we_i = ~we; core_size_i = 3'd0;
        core_addr_i = 32'hFFFF_FFFF; core_wd_i = 32'hFFFF_FFFF;
        if (wn == 0) begin
            for (int i = 0; i < 20; i++) begin
                @(posedge clk_i) #1;
                if (!core_stall_o) break;
            end
            if (core_stall_o) chk("timeout_bound", 32'd1, 32'd0);
        end else begin
            repeat (wn - 1) @(posedge clk_i) #1;
            mem_ready_i = 1'b1; mem_rd_i = rdata;
            @(posedge clk_i) #1;
            mem_ready_i = 1'b0; mem_rd_i = 32'hA5A5_A5A5;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd2;
        core_addr_i = 32'h1234_5678; core_wd_i = 32'h5555_5555;
        mem_rd_i = 32'h0; mem_ready_i = 1'b0;
        #2;
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_stall", {31'd0, core_stall_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_rd", core_rd_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        core_req_i = 1'b0;
        rst_i = 1'b1;

        access(1'b0, 3'd2, 32'h104, 32'h0, 32'hDEAD_BEEF, 2, 4'hF, 32'h0, 32'hDEAD_BEEF);
        @(posedge clk_i) #1;
        chk("rd_hold", core_rd_o, 32'hDEAD_BEEF);
        access(1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF_7F01, 1, 4'hF, 32'h0, 32'hFFFF_FF80);
        access(1'b0, 3'd4, 32'h203, 32'h0, 32'h80FF_7F01, 1, 4'hF, 32'h0, 32'h0000_0080);
        access(1'b0, 3'd0, 32'h200, 32'h0, 32'h80FF_7F01, 1, 4'hF, 32'h0, 32'h0000_0001);
        access(1'b0, 3'd1, 32'h202, 32'h0, 32'h80FF_7F01, 1, 4'hF, 32'h0, 32'hFFFF_80FF);
        access(1'b0, 3'd5, 32'h201, 32'h0, 32'h80FF_7F01, 1, 4'hF, 32'h0, 32'h0000_7F01);
        access(1'b0, 3'd3, 32'h201, 32'h0, 32'h80FF_7F01, 1, 4'hF, 32'h0, 32'h80FF_7F01);
        access(1'b1, 3'd1, 32'h302, 32'h1234_ABCD, 32'hFFFF_FFFF, 1, 4'b1100,
               32'hABCD_ABCD, 32'h0);
        access(1'b1, 3'd0, 32'h101, 32'h0000_0055, 32'hFFFF_FFFF, 1, 4'b0010,
               32'h5555_5555, 32'h0);
        access(1'b1, 3'd2, 32'h107, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 4'hF,
               32'hCAFE_F00D, 32'h0);
        access(1'b1, 3'd7, 32'h101, 32'h89AB_CDEF, 32'hFFFF_FFFF, 1, 4'hF,
               32'h89AB_CDEF, 32'h0);
        access(1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 0, 4'hF, 32'h0, 32'h0);

        push(1'b0, 32'h700, 4'hF, 32'h0, 32'h0, 1'b0, 0);
        @(posedge clk_i) #1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
        core_addr_i = 32'h700; core_wd_i = 32'h0;
        @(posedge clk_i) #1;
        core_req_i = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        chk("arst_req", {31'd0, mem_req_o}, 32'd0);
        chk("arst_stall", {31'd0, core_stall_o}, 32'd0);
        chk("arst_fault", {31'd0, access_fault_o}, 32'd0);
        void'(q.pop_front());
        @(posedge clk_i) #1;
        rst_i = 1'b1;
        access(1'b0, 3'd2, 32'h500, 32'h0, 32'h1357_9BDF, 1, 4'hF, 32'h0, 32'h1357_9BDF);

        push(1'b0, 32'h600, 4'hF, 32'h0, 32'h1111_1111, 1'b0, 2);
        push(1'b0, 32'h604, 4'hF, 32'h0, 32'h2222_2222, 1'b0, 2);
        @(posedge clk_i) #1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
        core_addr_i = 32'h600; core_wd_i = 32'h0;
        @(posedge clk_i) #1;
        mem_ready_i = 1'b1; mem_rd_i = 32'h1111_1111;
        @(posedge clk_i) #1;
        mem_ready_i = 1'b0;
        chk("b2b_done_stall", {31'd0, core_stall_o}, 32'd0);
        chk("b2b_done_req", {31'd0, mem_req_o}, 32'd0);
        core_addr_i = 32'h604;
        @(posedge clk_i) #1;
        chk("b2b_reissue", {31'd0, mem_req_o}, 32'd1);
        @(posedge clk_i) #1;
        mem_ready_i = 1'b1; mem_rd_i = 32'h2222_2222;
        @(posedge clk_i) #1;
        mem_ready_i = 1'b0; core_req_i = 1'b0;

        repeat (3) @(posedge clk_i);
        #1;
        chk("queue_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
